// File: rtl/cpu_bus_cycle_master_pkg.sv
// Shared types for the 8088-style bus cycle master: status codes, T-states
// and small helpers that classify a status code as a read or write cycle.
package cpu_bus_pkg;

   typedef enum logic [2:0] {
      ST_INTA  = 3'b000,
      ST_IORD  = 3'b001,
      ST_IOWR  = 3'b010,
      ST_HALT  = 3'b011,
      ST_CODE  = 3'b100,
      ST_MEMRD = 3'b101,
      ST_MEMWR = 3'b110,
      PASSIVE  = 3'b111
   } bus_status_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TW   = 3'd4,
      S_T4   = 3'd5,
      S_TI   = 3'd6
   } bus_state_t;

   // Cycles whose data phase captures cpu_data_in.
   function automatic logic is_read(input bus_status_t s);
      return (s == ST_INTA) || (s == ST_IORD) || (s == ST_CODE) || (s == ST_MEMRD);
   endfunction

   // Cycles that drive cpu_data_bus from T1 through T4.
   function automatic logic is_write(input bus_status_t s);
      return (s == ST_IOWR) || (s == ST_MEMWR);
   endfunction

endpackage

// File: rtl/cpu_bus_cycle_master.sv
// 8088-style bus initiator. Each accepted request runs one T-state sequence
// (two locked-then-unlocked cycles for INTA) and ends in a one-clock response.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while the FSM is IDLE and
// reset is low, and req_type/req_address/req_data are captured on that edge.
// rsp_valid is a single-clock strobe with rsp_data/rsp_error valid alongside;
// there is no back-pressure on the response side.
module cpu_bus_cycle_master
   import cpu_bus_pkg::*;
#(
   parameter int MIN_WAIT_STATES = 1,
   parameter int READY_TIMEOUT   = 1023,
   parameter int IDLE_GAP        = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_type,
   input  logic [19:0] req_address,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_error,
   output logic [19:0] cpu_address,
   output logic [7:0]  cpu_data_bus,
   output logic        cpu_data_oe,
   input  logic [7:0]  cpu_data_in,
   output logic [2:0]  processor_status,
   output logic        processor_lock_n,
   input  logic        processor_ready,
   output logic        busy,
   output bus_state_t  dbg_state
);

   localparam int TMO_W  = $clog2(READY_TIMEOUT + 1);
   localparam int WAIT_W = $clog2(MIN_WAIT_STATES + 2);
   localparam int GAP_W  = $clog2(IDLE_GAP + 2);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(READY_TIMEOUT - 1);
   localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(READY_TIMEOUT);
   // Ready is sampled at the end of the last forced TW clock and every TW clock after it.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MIN_WAIT_STATES == 0) ? 0 : MIN_WAIT_STATES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

   bus_state_t        state_q, state_d;
   bus_status_t       kind_q, kind_d;
   logic [19:0]       addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              abort_q, abort_d;
   logic              inta_first_q, inta_first_d;
   logic              inta_again_q, inta_again_d;
   logic              null_rsp_q, null_rsp_d;
   logic [7:0]        rsp_data_q, rsp_data_d;
   logic              sample;
   logic              active;
   logic              bus_cycle;

   // Next-state logic: T-state sequencing, wait/timeout counting and response data capture.
   always_comb begin
      state_d      = state_q;
      kind_d       = kind_q;
      addr_d       = addr_q;
      data_d       = data_q;
      wait_cnt_d   = wait_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      abort_d      = abort_q;
      inta_first_d = inta_first_q;
      inta_again_d = inta_again_q;
      null_rsp_d   = 1'b0;
      rsp_data_d   = rsp_data_q;
      sample       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_type == 3'b111) begin
                  // Passive code: no bus activity, just an empty response.
                  null_rsp_d = 1'b1;
                  rsp_data_d = 8'h00;
               end else begin
                  kind_d       = bus_status_t'(req_type);
                  addr_d       = req_address;
                  data_d       = req_data;
                  abort_d      = 1'b0;
                  inta_first_d = (req_type == ST_INTA);
                  inta_again_d = 1'b0;
                  state_d      = S_T1;
               end
            end
         end
         S_T1: begin
            wait_cnt_d   = '0;
            tmo_cnt_d    = '0;
            abort_d      = 1'b0;
            inta_again_d = 1'b0;
            state_d      = S_T2;
         end
         S_T2: begin
            if (kind_q == ST_HALT) begin
               rsp_data_d = 8'h00;
               state_d    = S_T4;
            end else begin
               state_d = S_T3;
            end
         end
         S_T3: begin
            if (MIN_WAIT_STATES > 0) state_d = S_TW;
            else                     sample  = 1'b1;
         end
         S_TW: begin
            if (wait_cnt_q == WAIT_LAST) sample     = 1'b1;
            else                         wait_cnt_d = wait_cnt_q + 1'b1;
         end
         S_T4: begin
            gap_cnt_d = '0;
            if (inta_first_q && !abort_q) begin
               inta_first_d = 1'b0;
               inta_again_d = 1'b1;
               state_d      = (IDLE_GAP == 0) ? S_T1 : S_TI;
            end else begin
               inta_first_d = 1'b0;
               state_d      = (IDLE_GAP == 0) ? S_IDLE : S_TI;
            end
         end
         S_TI: begin
            if (gap_cnt_q == GAP_LAST) state_d = inta_again_q ? S_T1 : S_IDLE;
            else                       gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // READY sampling clock: finish on ready, abort on timeout, else keep waiting.
      if (sample) begin
         if (processor_ready) begin
            state_d = S_T4;
            if (!inta_first_q) rsp_data_d = is_read(kind_q) ? cpu_data_in : 8'h00;
         end else if (tmo_cnt_q >= TMO_LAST) begin
            state_d    = S_T4;
            abort_d    = 1'b1;
            rsp_data_d = 8'h00;
         end else begin
            state_d = S_TW;
            if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
   end

   // State and datapath registers; reset abandons any cycle in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         kind_q       <= PASSIVE;
         addr_q       <= '0;
         data_q       <= '0;
         wait_cnt_q   <= '0;
         tmo_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         abort_q      <= 1'b0;
         inta_first_q <= 1'b0;
         inta_again_q <= 1'b0;
         null_rsp_q   <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         kind_q       <= kind_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         wait_cnt_q   <= wait_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         abort_q      <= abort_d;
         inta_first_q <= inta_first_d;
         inta_again_q <= inta_again_d;
         null_rsp_q   <= null_rsp_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign active    = (state_q == S_T1) || (state_q == S_T2) || (state_q == S_T3) || (state_q == S_TW);
   assign bus_cycle = active || (state_q == S_T4);

   assign processor_status = active ? kind_q : PASSIVE;
   assign cpu_address      = bus_cycle ? addr_q : 20'h0;
   assign cpu_data_oe      = bus_cycle && is_write(kind_q);
   assign cpu_data_bus     = cpu_data_oe ? data_q : 8'h00;
   assign processor_lock_n = !(bus_cycle && inta_first_q);
   assign rsp_valid        = null_rsp_q || ((state_q == S_T4) && (!inta_first_q || abort_q));
   assign rsp_error        = (state_q == S_T4) && abort_q;
   assign rsp_data         = rsp_data_q;
   assign busy             = (state_q != S_IDLE);
   assign req_ready        = (state_q == S_IDLE) && !reset;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_cpu_bus_cycle_master.sv
// Directed bench for cpu_bus_cycle_master: a driver issues requests and traces
// the bus per clock, while a negedge monitor pops expected responses.
module tb_cpu_bus_cycle_master;
   import cpu_bus_pkg::*;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_type;
   logic [19:0] req_address;
   logic [7:0]  req_data;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_error;
   logic [19:0] cpu_address;
   logic [7:0]  cpu_data_bus;
   logic        cpu_data_oe;
   logic [7:0]  cpu_data_in;
   logic [2:0]  processor_status;
   logic        processor_lock_n;
   logic        processor_ready;
   logic        busy;
   bus_state_t  dbg_state;

   cpu_bus_cycle_master #(
      .MIN_WAIT_STATES(1),
      .READY_TIMEOUT  (8),
      .IDLE_GAP       (1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_type        (req_type),
      .req_address     (req_address),
      .req_data        (req_data),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_error       (rsp_error),
      .cpu_address     (cpu_address),
      .cpu_data_bus    (cpu_data_bus),
      .cpu_data_oe     (cpu_data_oe),
      .cpu_data_in     (cpu_data_in),
      .processor_status(processor_status),
      .processor_lock_n(processor_lock_n),
      .processor_ready (processor_ready),
      .busy            (busy),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;
   logic [8:0] exp_q[$];

   int tr_act, tr_lock, tr_oe, tr_bad, tr_clks;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // scoreboard monitor: every response strobe must match the oldest expectation
   always @(negedge clock) begin
      if (!reset && rsp_valid) begin
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL rsp_unexpected: got err=%0b data=%0h expected no response", rsp_error, rsp_data);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({rsp_error, rsp_data} === e) n_pass++;
            else $display("FAIL rsp_compare: got err=%0b data=%0h expected err=%0b data=%0h",
                          rsp_error, rsp_data, e[8], e[7:0]);
         end
      end
   end

   // driver: issue one request, steer READY/data per clock, trace the bus until idle
   task automatic drive_req(input logic [2:0] t, input logic [19:0] a, input logic [7:0] d,
                            input int low_clks, input logic [7:0] din_a, input logic [7:0] din_b,
                            input logic exp_err, input logic [7:0] exp_data);
      int   c;
      int   k;
      logic seen;
      logic second;
      logic done;
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clock);
         k++;
      end
      check("req_ready_before_issue", req_ready, 1);
      tr_act = 0; tr_lock = 0; tr_oe = 0; tr_bad = 0; tr_clks = 0;
      seen = 1'b0; second = 1'b0; done = 1'b0;
      exp_q.push_back({exp_err, exp_data});
      req_valid = 1'b1; req_type = t; req_address = a; req_data = d;
      processor_ready = 1'b0; cpu_data_in = 8'hEE;
      @(posedge clock); #1;
      req_valid = 1'b0;
      c = 1;
      processor_ready = (c > low_clks);
      cpu_data_in = !processor_ready ? 8'hEE : (second ? din_b : din_a);
      while (!done) begin
         @(negedge clock);
         tr_clks++;
         if (processor_status != 3'b111) begin
            tr_act++;
            seen = 1'b1;
            if (processor_status != t) tr_bad++;
            if (cpu_address != a) tr_bad++;
         end else if (seen) begin
            second = 1'b1;
         end
         if (!processor_lock_n) tr_lock++;
         if (cpu_data_oe) begin
            tr_oe++;
            if (cpu_data_bus != d) tr_bad++;
         end
         if (!busy) begin
            done = 1'b1;
         end else if (tr_clks >= 60) begin
            n_total++;
            $display("FAIL cycle_timeout: got busy after %0d clocks expected idle", tr_clks);
            done = 1'b1;
         end else begin
            @(posedge clock); #1;
            c++;
            processor_ready = (c > low_clks);
            cpu_data_in = !processor_ready ? 8'hEE : (second ? din_b : din_a);
         end
      end
      processor_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_type = 3'b000; req_address = '0; req_data = '0;
      cpu_data_in = 8'h00; processor_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_status", processor_status, 3'b111);
      check("rst_lock_n", processor_lock_n, 1);
      check("rst_address", cpu_address, 0);
      check("rst_data_bus", cpu_data_bus, 0);
      check("rst_data_oe", cpu_data_oe, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_error", rsp_error, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      reset = 1'b0;
      @(negedge clock);

      // IORD with READY high: four active clocks
      drive_req(3'b001, 20'h00062, 8'h00, 0, 8'hCC, 8'hCC, 1'b0, 8'hCC);
      check("iord_active", tr_act, 4);
      check("iord_clks", tr_clks, 7);
      check("iord_lock", tr_lock, 0);
      check("iord_oe", tr_oe, 0);
      check("iord_bad", tr_bad, 0);

      // passive code: immediate empty response, no bus activity
      drive_req(3'b111, 20'h12345, 8'h77, 0, 8'h00, 8'h00, 1'b0, 8'h00);
      check("null_active", tr_act, 0);
      check("null_oe", tr_oe, 0);

      // MEMWR: data driven T1..T4
      drive_req(3'b110, 20'hB8001, 8'h02, 0, 8'h99, 8'h99, 1'b0, 8'h00);
      check("memwr_active", tr_act, 4);
      check("memwr_oe", tr_oe, 5);
      check("memwr_bad", tr_bad, 0);

      // MEMRD with READY low for the first five TW clocks
      drive_req(3'b101, 20'h23456, 8'h00, 8, 8'h5A, 8'h5A, 1'b0, 8'h5A);
      check("memrd_wait_active", tr_act, 9);
      check("memrd_wait_bad", tr_bad, 0);

      // INTA pair: locked first cycle, second cycle's data returned
      drive_req(3'b000, 20'h00000, 8'h00, 0, 8'hFF, 8'h62, 1'b0, 8'h62);
      check("inta_active", tr_act, 8);
      check("inta_lock", tr_lock, 5);
      check("inta_clks", tr_clks, 13);
      check("inta_bad", tr_bad, 0);

      // HALT: T1, T2 then T4
      drive_req(3'b011, 20'h00000, 8'h00, 0, 8'h44, 8'h44, 1'b0, 8'h00);
      check("halt_active", tr_act, 2);
      check("halt_clks", tr_clks, 5);

      // IOWR with READY stuck low: abort after 8 not-ready clocks
      drive_req(3'b010, 20'h00061, 8'hA5, 1000, 8'h00, 8'h00, 1'b1, 8'h00);
      check("tmo_active", tr_act, 11);
      check("tmo_oe", tr_oe, 12);
      check("tmo_bad", tr_bad, 0);
      check("tmo_idle_busy", busy, 0);
      check("tmo_idle_status", processor_status, 3'b111);

      // reset during TW of MEMRD: no response, bus passive next clock
      req_valid = 1'b1; req_type = 3'b101; req_address = 20'h23456; req_data = 8'h00;
      processor_ready = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("pre_reset_in_tw_status", processor_status, 3'b101);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("midrst_status", processor_status, 3'b111);
      check("midrst_busy", busy, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_oe", cpu_data_oe, 0);
      reset = 1'b0;
      @(negedge clock);

      // CODE fetch after the abandoned cycle
      drive_req(3'b100, 20'hDEF01, 8'h00, 0, 8'h3C, 8'h3C, 1'b0, 8'h3C);
      check("code_active", tr_act, 4);
      check("code_bad", tr_bad, 0);

      repeat (3) @(negedge clock);
      check("scoreboard_empty", exp_q.size(), 0);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "bench time limit");
   end

endmodule
